// File: rtl/path_segment_pipe_if.sv
// Operand/result handshake bundle for path_segment_pipe.
// master drives operands and out_ready; slave returns in_ready and the result.
interface path_segment_pipe_if #(
   parameter int unsigned W = 16
);
   logic [W-1:0] r1;
   logic [W-1:0] r2;
   logic [W-1:0] r3;
   logic [W-1:0] r4;
   logic         sel_a;
   logic         sel_b;
   logic [1:0]   op;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] regout;
   logic         ovf;

   modport master (
      output r1, r2, r3, r4, sel_a, sel_b, op, in_valid, out_ready,
      input  in_ready, out_valid, regout, ovf
   );

   modport slave (
      input  r1, r2, r3, r4, sel_a, sel_b, op, in_valid, out_ready,
      output in_ready, out_valid, regout, ovf
   );
endinterface

// File: rtl/path_segment_pipe.sv
// Two-stage ADD/MUL/MAC pipeline: S1 holds selected operands, S2 holds the result.
// A single advance signal stalls both stages together when the output is blocked.
module path_segment_pipe #(
   parameter int unsigned W  = 16,
   parameter int unsigned MW = W / 2
) (
   input  logic               clk,
   input  logic               rst,
   path_segment_pipe_if.slave pipe_io
);
   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_MUL    = 2'b01;
   localparam logic [1:0] OP_MAC    = 2'b10;
   localparam logic [1:0] OP_MACCLR = 2'b11;

   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [1:0]   op_q, op_d;
   logic         s1_valid_q, s1_valid_d;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] regout_q, regout_d;
   logic         ovf_q, ovf_d;
   logic         out_valid_q, out_valid_d;

   logic         adv_c;
   logic         take_c;
   logic [W-1:0] prod_c;
   logic [W:0]   sum_c;

   assign adv_c  = !out_valid_q || pipe_io.out_ready;
   assign take_c = pipe_io.in_valid && adv_c;
   assign prod_c = W'(a_q[MW-1:0]) * W'(b_q[MW-1:0]);

   assign pipe_io.in_ready  = adv_c;
   assign pipe_io.out_valid = out_valid_q;
   assign pipe_io.regout    = regout_q;
   assign pipe_io.ovf       = ovf_q;

   // S1: operand selection; a non-transfer advance inserts a bubble
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      s1_valid_d = s1_valid_q;
      if (adv_c) begin
         s1_valid_d = take_c;
         if (take_c) begin
            a_d  = pipe_io.sel_a ? pipe_io.r3 : pipe_io.r1;
            b_d  = pipe_io.sel_b ? pipe_io.r4 : pipe_io.r2;
            op_d = pipe_io.op;
         end
      end
   end

   // S2: compute result; accumulator reads acc_q directly so chained MACs see no gap
   always_comb begin
      regout_d    = regout_q;
      ovf_d       = ovf_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      sum_c       = '0;
      if (adv_c) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            case (op_q)
               OP_ADD: begin
                  sum_c    = {1'b0, a_q} + {1'b0, b_q};
                  regout_d = sum_c[W-1:0];
                  ovf_d    = sum_c[W];
               end
               OP_MUL: begin
                  regout_d = prod_c;
                  ovf_d    = 1'b0;
               end
               OP_MAC: begin
                  sum_c    = {1'b0, acc_q} + {1'b0, prod_c};
                  regout_d = sum_c[W-1:0];
                  ovf_d    = sum_c[W];
                  acc_d    = sum_c[W-1:0];
               end
               OP_MACCLR: begin
                  regout_d = prod_c;
                  ovf_d    = 1'b0;
                  acc_d    = prod_c;
               end
               default: begin
                  regout_d = regout_q;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         regout_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         s1_valid_q  <= s1_valid_d;
         acc_q       <= acc_d;
         regout_q    <= regout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_path_segment_pipe.sv
// Scoreboard bench for path_segment_pipe: expectations are queued on input transfer
// and popped when the output handshake completes.
module tb_path_segment_pipe;
   localparam int unsigned W = 16;
   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_MUL    = 2'b01;
   localparam logic [1:0] OP_MAC    = 2'b10;
   localparam logic [1:0] OP_MACCLR = 2'b11;

   typedef struct packed {
      logic [1:0]   op;
      logic         sa;
      logic         sb;
      logic [W-1:0] r1;
      logic [W-1:0] r2;
      logic [W-1:0] r3;
      logic [W-1:0] r4;
   } item_t;

   typedef struct packed {
      logic [W-1:0] val;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   path_segment_pipe_if #(.W(W)) bus ();
   path_segment_pipe #(.W(W)) dut (.clk(clk), .rst(rst), .pipe_io(bus));

   exp_t         sb[$];
   int           passed = 0;
   int           total  = 0;
   logic [W-1:0] m_acc  = '0;

   function automatic item_t mk(input logic [1:0] op, input logic sa, input logic sbit,
                                input logic [W-1:0] r1, input logic [W-1:0] r2,
                                input logic [W-1:0] r3, input logic [W-1:0] r4);
      item_t it;
      it.op = op; it.sa = sa; it.sb = sbit;
      it.r1 = r1; it.r2 = r2; it.r3 = r3; it.r4 = r4;
      return it;
   endfunction

   function automatic item_t rnd_item();
      return mk(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                W'($urandom), W'($urandom), W'($urandom), W'($urandom));
   endfunction

   task automatic drive(input logic v, input item_t it);
      bus.in_valid = v;
      bus.op       = it.op;
      bus.sel_a    = it.sa;
      bus.sel_b    = it.sb;
      bus.r1       = it.r1;
      bus.r2       = it.r2;
      bus.r3       = it.r3;
      bus.r4       = it.r4;
   endtask

   // Reference model of one item; advances the bench accumulator
   task automatic model_push(input item_t it);
      logic [W-1:0] a, b, prod;
      logic [W:0]   s;
      exp_t         e;
      a    = it.sa ? it.r3 : it.r1;
      b    = it.sb ? it.r4 : it.r2;
      prod = W'(a[7:0]) * W'(b[7:0]);
      case (it.op)
         OP_ADD:    begin s = {1'b0, a} + {1'b0, b}; e.val = s[W-1:0]; e.ovf = s[W]; end
         OP_MUL:    begin e.val = prod; e.ovf = 1'b0; end
         OP_MAC:    begin s = {1'b0, m_acc} + {1'b0, prod}; m_acc = s[W-1:0];
                          e.val = s[W-1:0]; e.ovf = s[W]; end
         default:   begin m_acc = prod; e.val = prod; e.ovf = 1'b0; end
      endcase
      sb.push_back(e);
   endtask

   task automatic test_reset();
      if (bus.out_valid !== 1'b0 || bus.regout !== 16'h0 || bus.ovf !== 1'b0) begin
         total++; $display("FAIL reset_out: out_valid=%b regout=%h ovf=%b required 0 0000 0",
                           bus.out_valid, bus.regout, bus.ovf);
      end else begin total++; passed++; end
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
      else passed++;
      rst = 1'b0;
      drive(1'b0, mk(OP_ADD, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         total++;
         if (bus.out_valid !== 1'b0) $display("FAIL reset_drop: out_valid=%b at cycle %0d required 0", bus.out_valid, c);
         else passed++;
      end
   endtask

   task automatic test_latency();
      exp_t e;
      @(negedge clk);
      drive(1'b1, mk(OP_ADD, 0, 0, 16'h1234, 16'h0001, 16'h5555, 16'h6666));
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL lat_accept: in_ready=%b required 1", bus.in_ready);
      else passed++;
      sb.push_back('{val: 16'h1235, ovf: 1'b0});
      @(negedge clk);
      drive(1'b0, mk(OP_ADD, 0, 0, 0, 0, 0, 0));
      #1;
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL lat_cycle1: out_valid=%b required 0", bus.out_valid);
      else passed++;
      @(negedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL lat_cycle2: out_valid=%b required 1", bus.out_valid);
      else passed++;
      if (bus.out_valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (bus.regout !== e.val || bus.ovf !== e.ovf)
            $display("FAIL lat_result: regout=%h ovf=%b required %h %b", bus.regout, bus.ovf, e.val, e.ovf);
         else passed++;
      end
      sb.delete();
      @(negedge clk); #1;
   endtask

   task automatic test_add_mul();
      item_t it[5];
      exp_t  ex[5];
      exp_t  e;
      int    k = 0;
      it[0] = mk(OP_ADD, 1, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002); ex[0] = '{16'h0001, 1'b1};
      it[1] = mk(OP_MUL, 0, 0, 16'hAB0F, 16'hCD10, 16'h0000, 16'h0000); ex[1] = '{16'h00F0, 1'b0};
      it[2] = mk(OP_ADD, 1, 0, 16'h1111, 16'h0023, 16'h0100, 16'h2222); ex[2] = '{16'h0123, 1'b0};
      it[3] = mk(OP_ADD, 0, 1, 16'h0010, 16'h7777, 16'h8888, 16'h0005); ex[3] = '{16'h0015, 1'b0};
      it[4] = mk(OP_MUL, 1, 1, 16'h0000, 16'h0000, 16'h12FF, 16'h34FF); ex[4] = '{16'hFE01, 1'b0};
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (k < 5) drive(1'b1, it[k]); else drive(1'b0, it[0]);
         #1;
         if (bus.in_valid && bus.in_ready) begin sb.push_back(ex[k]); k++; end
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) $display("FAIL add_mul: unexpected output regout=%h", bus.regout);
            else begin
               e = sb.pop_front();
               if (bus.regout !== e.val || bus.ovf !== e.ovf)
                  $display("FAIL add_mul: regout=%h ovf=%b required %h %b", bus.regout, bus.ovf, e.val, e.ovf);
               else passed++;
            end
         end
      end
      total++;
      if (sb.size() != 0 || k != 5) $display("FAIL add_mul_drain: %0d pending, %0d sent, required 0 and 5", sb.size(), k);
      else passed++;
      sb.delete();
   endtask

   task automatic test_mac_chain();
      item_t it[5];
      exp_t  ex[5];
      exp_t  e;
      int    k = 0;
      int    n_out = 0;
      int    out_cyc[3];
      it[0] = mk(OP_MACCLR, 0, 0, 16'd3, 16'd4, 16'd0, 16'd0); ex[0] = '{16'd12, 1'b0};
      it[1] = mk(OP_MAC,    0, 0, 16'd5, 16'd6, 16'd0, 16'd0); ex[1] = '{16'd42, 1'b0};
      it[2] = mk(OP_MAC,    0, 0, 16'd2, 16'd2, 16'd0, 16'd0); ex[2] = '{16'd46, 1'b0};
      it[3] = mk(OP_ADD,    0, 0, 16'd1, 16'd1, 16'd0, 16'd0); ex[3] = '{16'd2,  1'b0};
      it[4] = mk(OP_MAC,    0, 0, 16'd0, 16'd0, 16'd0, 16'd0); ex[4] = '{16'd46, 1'b0};
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (k < 5) drive(1'b1, it[k]); else drive(1'b0, it[0]);
         #1;
         if (bus.in_valid && bus.in_ready) begin sb.push_back(ex[k]); k++; end
         if (bus.out_valid && bus.out_ready) begin
            if (n_out < 3) out_cyc[n_out] = c;
            n_out++;
            total++;
            if (sb.size() == 0) $display("FAIL mac_chain: unexpected output regout=%h", bus.regout);
            else begin
               e = sb.pop_front();
               if (bus.regout !== e.val || bus.ovf !== e.ovf)
                  $display("FAIL mac_chain: regout=%0d ovf=%b required %0d %b", bus.regout, bus.ovf, e.val, e.ovf);
               else passed++;
            end
         end
      end
      total++;
      if (n_out < 3 || out_cyc[1] != out_cyc[0] + 1 || out_cyc[2] != out_cyc[1] + 1)
         $display("FAIL mac_consecutive: %0d outputs, first three not on consecutive cycles", n_out);
      else passed++;
      total++;
      if (sb.size() != 0 || k != 5) $display("FAIL mac_drain: %0d pending, %0d sent, required 0 and 5", sb.size(), k);
      else passed++;
      sb.delete();
      m_acc = 16'd46;
   endtask

   task automatic test_stall();
      item_t it;
      exp_t  e;
      int    k = 0;
      it = rnd_item();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         bus.out_ready = !(c >= 2 && c < 5);
         if (k < 6) drive(1'b1, it); else drive(1'b0, it);
         #1;
         if (c >= 2 && c < 5) begin
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || sb.size() == 0 || bus.regout !== sb[0].val)
               $display("FAIL stall_hold: in_ready=%b out_valid=%b regout=%h required 0 1 %h",
                        bus.in_ready, bus.out_valid, bus.regout, (sb.size() > 0) ? sb[0].val : 16'h0);
            else passed++;
         end
         if (bus.in_valid && bus.in_ready) begin model_push(it); k++; it = rnd_item(); end
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) $display("FAIL stall: unexpected output regout=%h", bus.regout);
            else begin
               e = sb.pop_front();
               if (bus.regout !== e.val || bus.ovf !== e.ovf)
                  $display("FAIL stall: regout=%h ovf=%b required %h %b", bus.regout, bus.ovf, e.val, e.ovf);
               else passed++;
            end
         end
      end
      total++;
      if (sb.size() != 0 || k != 6) $display("FAIL stall_drain: %0d pending, %0d sent, required 0 and 6", sb.size(), k);
      else passed++;
      sb.delete();
   endtask

   task automatic test_back_to_back();
      item_t it;
      exp_t  e;
      int    k = 0;
      it = rnd_item();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.out_ready = ($urandom_range(3) != 0);
         if (k < 40) drive(($urandom_range(3) != 0), it); else drive(1'b0, it);
         #1;
         if (bus.in_valid && bus.in_ready) begin model_push(it); k++; it = rnd_item(); end
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) $display("FAIL b2b: unexpected output regout=%h", bus.regout);
            else begin
               e = sb.pop_front();
               if (bus.regout !== e.val || bus.ovf !== e.ovf)
                  $display("FAIL b2b: regout=%h ovf=%b required %h %b", bus.regout, bus.ovf, e.val, e.ovf);
               else passed++;
            end
         end
      end
      bus.out_ready = 1'b1;
      total++;
      if (sb.size() != 0 || k != 40) $display("FAIL b2b_drain: %0d pending, %0d sent, required 0 and 40", sb.size(), k);
      else passed++;
      sb.delete();
   endtask

   task automatic test_reset_flush();
      exp_t e;
      bus.out_ready = 1'b0;
      @(negedge clk); drive(1'b1, mk(OP_MAC, 0, 0, 16'd7, 16'd9, 0, 0));
      @(negedge clk); drive(1'b1, mk(OP_MAC, 0, 0, 16'd3, 16'd5, 0, 0));
      @(negedge clk); drive(1'b0, mk(OP_MAC, 0, 0, 0, 0, 0, 0)); rst = 1'b1;
      @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.regout !== 16'h0 || bus.ovf !== 1'b0)
         $display("FAIL flush_state: out_valid=%b regout=%h ovf=%b required 0 0000 0", bus.out_valid, bus.regout, bus.ovf);
      else passed++;
      sb.delete();
      m_acc = '0;
      @(negedge clk); drive(1'b1, mk(OP_MAC, 0, 0, 16'd1, 16'd1, 0, 0));
      #1;
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_no_ghost: out_valid=%b required 0", bus.out_valid);
      else passed++;
      if (bus.in_ready) sb.push_back('{val: 16'd1, ovf: 1'b0});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); drive(1'b0, mk(OP_ADD, 0, 0, 0, 0, 0, 0));
         #1;
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sb.size() == 0) $display("FAIL flush_mac: unexpected output regout=%h", bus.regout);
            else begin
               e = sb.pop_front();
               if (bus.regout !== e.val || bus.ovf !== e.ovf)
                  $display("FAIL flush_mac: regout=%h ovf=%b required %h %b", bus.regout, bus.ovf, e.val, e.ovf);
               else passed++;
            end
         end
      end
      total++;
      if (sb.size() != 0) $display("FAIL flush_drain: %0d pending required 0", sb.size());
      else passed++;
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, mk(OP_ADD, 0, 0, 16'h0101, 16'h0202, 16'h0303, 16'h0404));
      repeat (2) @(negedge clk);
      #1;
      test_reset();
      test_latency();
      test_add_mul();
      test_mac_chain();
      test_stall();
      test_back_to_back();
      test_reset_flush();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
